// File: rtl/seq_mul_writer.sv
// Sequential shift-add multiplier (signed/unsigned) that writes a 2*WIDTH-bit product
// into the multiply-result register with a single-cycle RegWrite strobe.
module seq_mul_writer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic [2*WIDTH-1:0]   Data,
    output logic                 RegWrite
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StWrite} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   data_q, data_d;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            data_q   <= data_d;
        end
    end

    // Magnitudes: negating the most negative value wraps back to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        a_mag = A;
        b_mag = B;
        if (Signed && A[WIDTH-1]) a_mag = -A;
        if (Signed && B[WIDTH-1]) b_mag = -B;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        data_d   = data_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    neg_d    = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH - 1);
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFix: begin
                data_d  = neg_q ? -acc_q : acc_q;
                state_d = StWrite;
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobe decoded straight from state so an asynchronous reset kills it at once.
    assign Busy     = (state_q != StIdle);
    assign RegWrite = (state_q == StWrite);
    assign Data     = data_q;

endmodule
